// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl
//   Sequencing controller between the UART receive flag buffer, the ALU and
//   the UART transmitter. It accepts operand A, operand B and an opcode as
//   three consecutive received bytes and presents them to the ALU as
//   registered values. It then captures the ALU result and issues a single
//   transmit request, and returns for the next triple once the transmitter
//   reports completion.
//
//   Optional feature: define ALU_CTRL_TIMEOUT_EN to abandon a partial triple
//   after TO_CYCLES idle cycles in GET_B/GET_OP.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   rx_flag      receive buffer holds an unread byte
//   rx_data      received byte (valid while rx_flag)
//   clr_flag     one-cycle pulse consuming the current byte
//   alu_a/alu_b  registered operands
//   alu_op       registered opcode (low OPW bits of the opcode byte)
//   alu_res      combinational ALU result
//   tx_start     one-cycle transmitter start pulse
//   tx_data      registered byte to transmit
//   tx_done_tick one-cycle transmitter completion pulse
//   busy         high in EXEC, SEND and WAIT_TX
//   timeout      one-cycle pulse when a partial triple is abandoned
module alu_uart_ctrl #(
    parameter int W         = 8,
    parameter int OPW       = 6,
    parameter int TO_CYCLES = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_flag,
    input  logic [W-1:0]   rx_data,
    output logic           clr_flag,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_res,
    output logic           tx_start,
    output logic [W-1:0]   tx_data,
    input  logic           tx_done_tick,
    output logic           busy,
    output logic           timeout
);

    localparam logic [2:0] GET_A   = 3'd0;
    localparam logic [2:0] GET_B   = 3'd1;
    localparam logic [2:0] GET_OP  = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       in_get;
    logic       accept;
    logic       to_hit;

    assign in_get = (state == GET_A) || (state == GET_B) || (state == GET_OP);

    // Outputs are gated with reset so that an asserted reset never consumes
    // a buffered byte, even though the state already reads GET_A.
    assign accept   = !reset && in_get && rx_flag;
    assign clr_flag = accept;
    assign tx_start = !reset && (state == SEND);
    assign busy     = !reset && ((state == EXEC) || (state == SEND) || (state == WAIT_TX));
    assign timeout  = !reset && to_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            GET_A:   if (rx_flag) state_nxt = GET_B;
            GET_B:   if (rx_flag) state_nxt = GET_OP;
                     else if (to_hit) state_nxt = GET_A;
            GET_OP:  if (rx_flag) state_nxt = EXEC;
                     else if (to_hit) state_nxt = GET_A;
            EXEC:    state_nxt = SEND;
            SEND:    state_nxt = WAIT_TX;
            WAIT_TX: if (tx_done_tick) state_nxt = GET_A;
            default: state_nxt = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= GET_A;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept && (state == GET_A))  alu_a  <= rx_data;
            if (accept && (state == GET_B))  alu_b  <= rx_data;
            if (accept && (state == GET_OP)) alu_op <= rx_data[OPW-1:0];
            if (state == EXEC)               tx_data <= alu_res;
        end
    end

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] to_cnt;
    logic          waiting;

    assign waiting = ((state == GET_B) || (state == GET_OP)) && !rx_flag;
    assign to_hit  = waiting && (to_cnt == TO_LAST);

    // Clearing whenever the next state is GET_A covers both the entry into
    // GET_A and idling there, so the counter is always zero when a triple
    // starts; it holds (at zero) through EXEC/SEND/WAIT_TX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (accept || (state_nxt == GET_A)) begin
            to_cnt <= '0;
        end else if (waiting) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_ctrl.sv
module tb_alu_uart_ctrl;

    localparam int W   = 8;
    localparam int OPW = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           rx_flag;
    logic [W-1:0]   rx_data;
    logic           clr_flag;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_res;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_done_tick;
    logic           busy;
    logic           timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ALU model: addition, so the 0x05/0x03 triple yields 0x08.
    assign alu_res = alu_a + alu_b;

    alu_uart_ctrl #(.W(W), .OPW(OPW), .TO_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .rx_flag(rx_flag), .rx_data(rx_data),
        .clr_flag(clr_flag), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done_tick(tx_done_tick), .busy(busy), .timeout(timeout)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp_op;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one accept cycle; expects it to be consumed.
    task automatic send_byte(input logic [7:0] d, input string nm);
        rx_flag = 1'b1;
        rx_data = d;
        #1;
        chk({nm, " clr_flag"}, 32'(clr_flag), 32'd1);
        tick();
        rx_flag = 1'b0;
        #1;
        chk({nm, " clr_flag drop"}, 32'(clr_flag), 32'd0);
    endtask

    initial begin
        int txs;
        int clrs;
        int busy_low;
        int to_cnt;

        vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp_op: 8'h20, exp_tx: 8'h08};
        vecs[1] = '{a: 8'hFF, b: 8'h01, op: 8'hE2, exp_op: 8'h22, exp_tx: 8'h00};
        vecs[2] = '{a: 8'h7F, b: 8'h01, op: 8'hC1, exp_op: 8'h01, exp_tx: 8'h80};
        vecs[3] = '{a: 8'h0A, b: 8'hF0, op: 8'h3F, exp_op: 8'h3F, exp_tx: 8'hFA};

        // Reset with a byte pending: nothing may be consumed.
        reset = 1'b1; rx_flag = 1'b1; rx_data = 8'h5A; tx_done_tick = 1'b0;
        #3;
        chk("rst clr_flag", 32'(clr_flag), 32'd0);
        chk("rst tx_start", 32'(tx_start), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        chk("rst alu_a", 32'(alu_a), 32'd0);
        chk("rst alu_b", 32'(alu_b), 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        tick(); tick();
        rx_flag = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].a, "A");
            chk("alu_a", 32'(alu_a), 32'(vecs[i].a));
            chk("busy in GET_B", 32'(busy), 32'd0);
            send_byte(vecs[i].b, "B");
            chk("alu_b", 32'(alu_b), 32'(vecs[i].b));
            send_byte(vecs[i].op, "OP");
            // now EXEC
            chk("alu_op", 32'(alu_op), 32'(vecs[i].exp_op));
            chk("busy EXEC", 32'(busy), 32'd1);
            chk("tx_start EXEC", 32'(tx_start), 32'd0);
            tick();
            chk("tx_start SEND", 32'(tx_start), 32'd1);
            chk("tx_data", 32'(tx_data), 32'(vecs[i].exp_tx));
            tick();
            chk("tx_start WAIT", 32'(tx_start), 32'd0);
            chk("busy WAIT", 32'(busy), 32'd1);
            tx_done_tick = 1'b1;
            tick();
            tx_done_tick = 1'b0;
            #1;
            chk("busy after done", 32'(busy), 32'd0);
        end

        // Long WAIT_TX with a byte pending: no consume, one tx_start total.
        send_byte(8'h02, "A2");
        send_byte(8'h03, "B2");
        send_byte(8'h00, "OP2");
        tick();
        txs = 0; clrs = 0; busy_low = 0;
        rx_flag = 1'b1; rx_data = 8'h11;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (tx_start) txs++;
            if (clr_flag) clrs++;
            if (!busy) busy_low++;
            tick();
        end
        chk("tx_start count", 32'(txs), 32'd1);
        chk("clr while busy", 32'(clrs), 32'd0);
        chk("busy held", 32'(busy_low), 32'd0);
        chk("tx_data hold", 32'(tx_data), 32'd5);
        tx_done_tick = 1'b1;
        #1;
        chk("no clr on done cycle", 32'(clr_flag), 32'd0);
        tick();
        tx_done_tick = 1'b0;
        #1;
        chk("busy GET_A", 32'(busy), 32'd0);
        chk("clr first GET_A", 32'(clr_flag), 32'd1);
        tick();
        rx_flag = 1'b0;
        #1;
        chk("pending -> alu_a", 32'(alu_a), 32'h11);

        // Reset while in GET_OP with a byte pending.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_byte(8'h0A, "A3");
        send_byte(8'h0B, "B3");
        rx_flag = 1'b1; rx_data = 8'h55;
        reset = 1'b1;
        #1;
        chk("rst GET_OP clr", 32'(clr_flag), 32'd0);
        chk("rst GET_OP alu_a", 32'(alu_a), 32'd0);
        chk("rst GET_OP alu_b", 32'(alu_b), 32'd0);
        chk("rst GET_OP busy", 32'(busy), 32'd0);
        tick();
        chk("rst hold tx_start", 32'(tx_start), 32'd0);
        reset = 1'b0;
        rx_flag = 1'b0;
        tick();
        send_byte(8'h07, "A4");
        chk("post-reset alu_a", 32'(alu_a), 32'h07);
        chk("post-reset alu_b", 32'(alu_b), 32'd0);

        // Idle in GET_B: timeout behaviour depends on the build.
        to_cnt = 0;
        for (int c = 0; c < 20; c++) begin
`ifdef ALU_CTRL_TIMEOUT_EN
            chk("timeout pulse", 32'(timeout), (c == 15) ? 32'd1 : 32'd0);
`else
            if (timeout) to_cnt++;
`endif
            tick();
        end
        chk("timeout count", 32'(to_cnt), 32'd0);
        send_byte(8'h09, "after idle");
`ifdef ALU_CTRL_TIMEOUT_EN
        chk("abandoned -> alu_a", 32'(alu_a), 32'h09);
        chk("abandoned alu_b kept", 32'(alu_b), 32'd0);
`else
        chk("still GET_B alu_b", 32'(alu_b), 32'h09);
        chk("alu_a kept", 32'(alu_a), 32'h07);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
